instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/arm_enc_pkg.sv | 25 ++
 rtl/enc_word.sv | 40 ++++
 rtl/instr_encoder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/arm_enc_pkg.sv
// Shared encodings for the instruction encoder: op/cmd codes, FSM states, memory depth.
package arm_enc_pkg;

   typedef enum logic [1:0] {
      OP_DP  = 2'b00,
      OP_MEM = 2'b01,
      OP_BR  = 2'b10
   } op_e;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_EOR = 4'b0001;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_STREAM = 2'b01,
      ST_DONE   = 2'b10
   } state_e;

   localparam int IMEM_DEPTH = 64;
   localparam int ADDR_W     = 6;

endpackage

// File: rtl/enc_word.sv
// Combinational field packer and legality check; zero latency, no flow control.
// ENC_XOR_EN: when defined, data-processing cmd EOR is accepted as legal.
module enc_word
   import arm_enc_pkg::*;
(
   input  logic [3:0]  cond,
   input  logic [1:0]  op,
   input  logic [5:0]  funct,
   input  logic [3:0]  rn,
   input  logic [3:0]  rd,
   input  logic [11:0] src2,
   input  logic [23:0] imm24,
   output logic [31:0] word,
   output logic        legal
);

   always_comb begin
      word  = {cond, op, funct, rn, rd, src2};
      legal = 1'b0;
      case (op)
         OP_DP: begin
            case (funct[4:1])
               CMD_ADD, CMD_SUB, CMD_AND, CMD_ORR: legal = 1'b1;
`ifdef ENC_XOR_EN
               CMD_EOR: legal = 1'b1;
`endif
               default: legal = 1'b0;
            endcase
         end
         OP_MEM: legal = 1'b1;
         OP_BR: begin
            // Branches keep only the two link/flag bits of funct; rn/rd/src2 are replaced by the offset.
            word  = {cond, 2'b10, funct[5:4], imm24};
            legal = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Streams field descriptors into 32-bit words written to IMEM one cycle after acceptance.
// in_ready is high only in STREAM; ENC_XOR_EN enables EOR via enc_word.
module instr_encoder
   import arm_enc_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_last,
   input  logic [3:0]  in_cond,
   input  logic [1:0]  in_op,
   input  logic [5:0]  in_funct,
   input  logic [3:0]  in_rn,
   input  logic [3:0]  in_rd,
   input  logic [11:0] in_src2,
   input  logic [23:0] in_imm24,
   output logic        imem_we,
   output logic [5:0]  imem_addr,
   output logic [31:0] imem_wd,
   output logic        done,
   output logic        full,
   output logic [6:0]  word_count,
   output logic [7:0]  err_count
);

   localparam logic [6:0] LAST_CNT = 7'(IMEM_DEPTH - 1);

   state_e      state_q, state_d;
   logic        imem_we_q, imem_we_d;
   logic [5:0]  imem_addr_q, imem_addr_d;
   logic [31:0] imem_wd_q, imem_wd_d;
   logic [6:0]  word_count_q, word_count_d;
   logic [7:0]  err_count_q, err_count_d;
   logic        full_q, full_d;

   logic [31:0] enc_dat;
   logic        enc_legal;

   enc_word u_enc_word (
      .cond  (in_cond),
      .op    (in_op),
      .funct (in_funct),
      .rn    (in_rn),
      .rd    (in_rd),
      .src2  (in_src2),
      .imm24 (in_imm24),
      .word  (enc_dat),
      .legal (enc_legal)
   );

   always_comb begin
      state_d      = state_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wd_d    = imem_wd_q;
      word_count_d = word_count_q;
      err_count_d  = err_count_q;
      full_d       = full_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d      = ST_STREAM;
               imem_addr_d  = '0;
               word_count_d = '0;
               err_count_d  = '0;
               full_d       = 1'b0;
            end
         end
         ST_STREAM: begin
            if (in_valid) begin
               if (enc_legal) begin
                  // word_count doubles as the next write address; it never reaches 64 while streaming.
                  imem_we_d    = 1'b1;
                  imem_wd_d    = enc_dat;
                  imem_addr_d  = word_count_q[5:0];
                  word_count_d = word_count_q + 7'd1;
                  if (word_count_q == LAST_CNT) begin
                     full_d  = 1'b1;
                     state_d = ST_DONE;
                  end
               end else if (err_count_q != 8'hFF) begin
                  err_count_d = err_count_q + 8'd1;
               end
               if (in_last) state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wd_q    <= '0;
         word_count_q <= '0;
         err_count_q  <= '0;
         full_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wd_q    <= imem_wd_d;
         word_count_q <= word_count_d;
         err_count_q  <= err_count_d;
         full_q       <= full_d;
      end
   end

   assign in_ready   = (state_q == ST_STREAM);
   assign done       = (state_q == ST_DONE);
   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wd    = imem_wd_q;
   assign word_count = word_count_q;
   assign err_count  = err_count_q;
   assign full       = full_q;

endmodule
